prio_arb_rr: RTL

Parametrised, registered successor to the 8-bit combinational priority encoder. It takes N request lines and selects one index per cycle, in one of two modes: fixed priority (highest index wins) or round-robin. The chosen index is presented on a valid/ready output handshake and held stable until the consumer accepts it. It sits between request sources (interrupt lines, FIFO-not-empty flags) and a single shared consumer.

---
 rtl/prio_arb_pkg.sv | 11 +
 rtl/prio_arb_rr_pe_nb.sv | 22 ++
 rtl/prio_arb_rr.sv | 119 +++++++++++
 3 files changed

// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the prio_arb_rr arbiter.
package prio_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } prio_mode_t;

    localparam int unsigned PRIO_CNT_W = 16;

endpackage : prio_arb_pkg

// File: rtl/prio_arb_rr_pe_nb.sv
// Combinational parametric priority encoder: the highest set index wins.
module pe_nb #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] in,
    output logic         val,
    output logic [W-1:0] out
);

    // Scan upward so the last (highest) set bit overwrites lower ones
    always_comb begin
        val = |in;
        out = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (in[i]) begin
                out = W'(i);
            end
        end
    end

endmodule : pe_nb

// File: rtl/prio_arb_rr.sv
// Registered N-way arbiter (fixed priority or round-robin) on a valid/ready output.
// Optional accepted-grant counter on grant_cnt when PRIO_ARB_STATS_EN is defined.
module prio_arb_rr
    import prio_arb_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  mode,
    output logic                  out_valid,
    output logic [W-1:0]          out_idx,
    input  logic                  out_ready
`ifdef PRIO_ARB_STATS_EN
    ,
    output logic [PRIO_CNT_W-1:0] grant_cnt
`endif
);

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_idx_q, out_idx_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           accept_c, load_c;
    logic [N-1:0]   req_masked_c;
    logic           mask_val_c, full_val_c;
    logic [W-1:0]   mask_idx_c, full_idx_c;
    logic [W-1:0]   winner_c;
    prio_mode_t     mode_e;

    assign mode_e = prio_mode_t'(mode);

    // Handshake decode and post-accept pointer (feeds this cycle's search)
    always_comb begin
        accept_c = out_valid_q && out_ready;
        load_c   = !out_valid_q || out_ready;
        ptr_d    = ptr_q;
        if (accept_c) begin
            ptr_d = (out_idx_q == '0) ? W'(N - 1) : out_idx_q - W'(1);
        end
    end

    // Keep only requests at or below the round-robin pointer
    always_comb begin
        req_masked_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            req_masked_c[i] = req[i] && (W'(i) <= ptr_d);
        end
    end

    pe_nb #(.N(N)) u_pe_mask (
        .in  (req_masked_c),
        .val (mask_val_c),
        .out (mask_idx_c)
    );

    pe_nb #(.N(N)) u_pe_full (
        .in  (req),
        .val (full_val_c),
        .out (full_idx_c)
    );

    // Winner select and output next-state; outputs freeze while held
    always_comb begin
        winner_c    = full_idx_c;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (mode_e == MODE_RR && mask_val_c) begin
            winner_c = mask_idx_c;
        end
        if (load_c) begin
            out_valid_d = full_val_c;
            if (full_val_c) begin
                out_idx_d = winner_c;
            end
        end
    end

    // Output and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;

`ifdef PRIO_ARB_STATS_EN
    logic [PRIO_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of accepted grants
    always_comb begin
        cnt_d = cnt_q;
        if (accept_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + PRIO_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule : prio_arb_rr
